// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Dual-lane instruction queue that sits between IF and ID in place of the
//   IF/ID pipeline register. IF pushes up to two {inst, pc} pairs per cycle.
//   ID sees the two oldest entries and consumes 0..2 of them per cycle.
//   A branch redirect empties the queue.
//
//   Optional feature: INST_QUEUE_BYPASS_EN
//     When this macro is defined and the queue is empty (and no flush is
//     requested), the incoming lanes are forwarded to the outputs in the same
//     cycle. The default build has no combinational path from inputs to
//     outputs.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 4)
//   XLEN   width of the instruction and PC fields
//   CNT_W  occupancy counter width (derived, not overridable)
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   in_valid1/2   push lanes; lane 1 is the older one, lane 2 needs lane 1
//   inst_in1/2    pushed instructions
//   inst_pc1/2    pushed PCs
//   out_valid1/2  head / head+1 valid
//   inst_out1/2   head / head+1 instruction (zero when invalid)
//   pc_out1/2     head / head+1 PC (zero when invalid)
//   out_pop       number of entries consumed by ID this cycle
//   branch_flag   flush request
//   instbuf_full  fewer than two free slots; IF must hold off
//   inst_count    current occupancy
// ---------------------------------------------------------------------------
module inst_queue #(
  parameter int  DEPTH = 8,
  parameter int  XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic [XLEN-1:0]  inst_in1,
  input  logic [XLEN-1:0]  inst_in2,
  input  logic [XLEN-1:0]  inst_pc1,
  input  logic [XLEN-1:0]  inst_pc2,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [XLEN-1:0]  inst_out1,
  output logic [XLEN-1:0]  inst_out2,
  output logic [XLEN-1:0]  pc_out1,
  output logic [XLEN-1:0]  pc_out2,
  input  logic [1:0]       out_pop,
  input  logic             branch_flag,
  output logic             instbuf_full,
  output logic [CNT_W-1:0] inst_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  inst_mem_r [DEPTH];
  logic [XLEN-1:0]  pc_mem_r   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             empty_s;
  logic             bypass_s;
  logic             push_ok_s;
  logic [1:0]       n_push_s;
  logic [CNT_W-1:0] push_cnt_s;
  logic [CNT_W-1:0] avail_s;
  logic [CNT_W-1:0] pop_req_s;
  logic [CNT_W-1:0] eff_pop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_p1_s;
  logic [PTR_W-1:0] wr_ptr_p1_s;

  // Status flags derived from the registered occupancy.
  always_comb begin
    // Full means fewer than two free slots, i.e. count > DEPTH-2.
    full_s  = (count_r > CNT_W'(DEPTH - 2));
    empty_s = (count_r == {CNT_W{1'b0}});
`ifdef INST_QUEUE_BYPASS_EN
    bypass_s = empty_s & ~branch_flag;
`else
    bypass_s = 1'b0;
`endif
  end

  // Push/pop bookkeeping and next-state values for pointers and count.
  always_comb begin
    n_push_s  = {1'b0, in_valid1} + {1'b0, in_valid1 & in_valid2};
    // Acceptance is judged on the pre-pop count: slots freed by this
    // cycle's pop are not reusable until the next cycle.
    push_ok_s = in_valid1 & ~full_s;
    if (push_ok_s) begin
      push_cnt_s = CNT_W'(n_push_s);
    end else begin
      push_cnt_s = {CNT_W{1'b0}};
    end
    // In bypass, ID may only consume what is being pushed right now.
    if (bypass_s) begin
      avail_s = push_cnt_s;
    end else begin
      avail_s = count_r;
    end
    pop_req_s = CNT_W'(out_pop);
    if (pop_req_s > avail_s) begin
      eff_pop_s = avail_s;
    end else begin
      eff_pop_s = pop_req_s;
    end
    // Bypassed entries are written and then skipped by the read pointer,
    // which leaves only the non-popped pushes visible.
    count_nxt_s  = count_r + push_cnt_s - eff_pop_s;
    rd_ptr_nxt_s = rd_ptr_r + eff_pop_s[PTR_W-1:0];
    wr_ptr_nxt_s = wr_ptr_r + push_cnt_s[PTR_W-1:0];
    rd_ptr_p1_s  = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    wr_ptr_p1_s  = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
  end

  // Pointer and occupancy registers; a flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (branch_flag) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Entry storage: lane 1 at wr_ptr, lane 2 at wr_ptr+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= {XLEN{1'b0}};
        pc_mem_r[i]   <= {XLEN{1'b0}};
      end
    end else if (push_ok_s && !branch_flag) begin
      inst_mem_r[wr_ptr_r] <= inst_in1;
      pc_mem_r[wr_ptr_r]   <= inst_pc1;
      if (in_valid2) begin
        inst_mem_r[wr_ptr_p1_s] <= inst_in2;
        pc_mem_r[wr_ptr_p1_s]   <= inst_pc2;
      end else begin
        inst_mem_r[wr_ptr_p1_s] <= inst_mem_r[wr_ptr_p1_s];
        pc_mem_r[wr_ptr_p1_s]   <= pc_mem_r[wr_ptr_p1_s];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= inst_mem_r[i];
        pc_mem_r[i]   <= pc_mem_r[i];
      end
    end
  end

  // Output lanes: stored head entries, or the inputs while bypassing.
  always_comb begin
    out_valid1 = 1'b0;
    out_valid2 = 1'b0;
    inst_out1  = {XLEN{1'b0}};
    inst_out2  = {XLEN{1'b0}};
    pc_out1    = {XLEN{1'b0}};
    pc_out2    = {XLEN{1'b0}};
    if (bypass_s) begin
      out_valid1 = in_valid1;
      out_valid2 = in_valid1 & in_valid2;
      if (in_valid1) begin
        inst_out1 = inst_in1;
        pc_out1   = inst_pc1;
      end else begin
        inst_out1 = {XLEN{1'b0}};
        pc_out1   = {XLEN{1'b0}};
      end
      if (in_valid1 && in_valid2) begin
        inst_out2 = inst_in2;
        pc_out2   = inst_pc2;
      end else begin
        inst_out2 = {XLEN{1'b0}};
        pc_out2   = {XLEN{1'b0}};
      end
    end else begin
      out_valid1 = (count_r >= CNT_W'(1));
      out_valid2 = (count_r >= CNT_W'(2));
      if (out_valid1) begin
        inst_out1 = inst_mem_r[rd_ptr_r];
        pc_out1   = pc_mem_r[rd_ptr_r];
      end else begin
        inst_out1 = {XLEN{1'b0}};
        pc_out1   = {XLEN{1'b0}};
      end
      if (out_valid2) begin
        inst_out2 = inst_mem_r[rd_ptr_p1_s];
        pc_out2   = pc_mem_r[rd_ptr_p1_s];
      end else begin
        inst_out2 = {XLEN{1'b0}};
        pc_out2   = {XLEN{1'b0}};
      end
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    instbuf_full = full_s;
    inst_count   = count_r;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=8, XLEN=32).
// A queue-based model predicts every output each cycle; directed sequences
// add literal expectations that pin the model.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid1, in_valid2;
  logic [XLEN-1:0]  inst_in1, inst_in2, inst_pc1, inst_pc2;
  logic             out_valid1, out_valid2;
  logic [XLEN-1:0]  inst_out1, inst_out2, pc_out1, pc_out2;
  logic [1:0]       out_pop;
  logic             branch_flag;
  logic             instbuf_full;
  logic [CNT_W-1:0] inst_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [63:0] q_m [$];   // {inst, pc}, front = oldest

  inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .inst_in1(inst_in1), .inst_in2(inst_in2),
    .inst_pc1(inst_pc1), .inst_pc2(inst_pc2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .inst_out1(inst_out1), .inst_out2(inst_out2),
    .pc_out1(pc_out1), .pc_out2(pc_out2),
    .out_pop(out_pop), .branch_flag(branch_flag),
    .instbuf_full(instbuf_full), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_bypass();
`ifdef INST_QUEUE_BYPASS_EN
    return (q_m.size() == 0) && !branch_flag;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] inst_of(input int k);
    return 32'hA000_0000 + k;
  endfunction

  function automatic logic [31:0] pc_of(input int k);
    return 32'h0000_1000 + 4 * k;
  endfunction

  // Model step for the inputs present at the posedge just passed.
  task automatic model_update();
    int np;
    int pp;
    bit full;
    np = in_valid1 ? (in_valid2 ? 2 : 1) : 0;
    pp = int'(out_pop);
    if (branch_flag) begin
      q_m.delete();
    end else if (model_bypass()) begin
      if (np >= 1) q_m.push_back({inst_in1, inst_pc1});
      if (np == 2) q_m.push_back({inst_in2, inst_pc2});
      for (int i = 0; i < pp && q_m.size() > 0; i++) void'(q_m.pop_front());
    end else begin
      full = (DEPTH - q_m.size()) < 2;
      for (int i = 0; i < pp && q_m.size() > 0; i++) void'(q_m.pop_front());
      if (!full) begin
        if (np >= 1) q_m.push_back({inst_in1, inst_pc1});
        if (np == 2) q_m.push_back({inst_in2, inst_pc2});
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        v1, v2;
    logic [31:0] i1, i2, p1, p2;
    if (cmp_en) begin
      if (model_bypass()) begin
        v1 = in_valid1;
        v2 = in_valid1 & in_valid2;
        i1 = v1 ? inst_in1 : 32'h0;
        p1 = v1 ? inst_pc1 : 32'h0;
        i2 = v2 ? inst_in2 : 32'h0;
        p2 = v2 ? inst_pc2 : 32'h0;
      end else begin
        v1 = (q_m.size() >= 1);
        v2 = (q_m.size() >= 2);
        i1 = v1 ? q_m[0][63:32] : 32'h0;
        p1 = v1 ? q_m[0][31:0]  : 32'h0;
        i2 = v2 ? q_m[1][63:32] : 32'h0;
        p2 = v2 ? q_m[1][31:0]  : 32'h0;
      end
      chk("m_valid1", out_valid1, v1);
      chk("m_valid2", out_valid2, v2);
      chk("m_inst1", inst_out1, i1);
      chk("m_inst2", inst_out2, i2);
      chk("m_pc1", pc_out1, p1);
      chk("m_pc2", pc_out2, p2);
      chk("m_full", instbuf_full, (DEPTH - q_m.size()) < 2);
      chk("m_count", inst_count, q_m.size());
    end
  end

  task automatic drive(input logic v1, input logic v2,
                       input logic [31:0] i1, input logic [31:0] p1,
                       input logic [31:0] i2, input logic [31:0] p2,
                       input logic [1:0] pop, input logic br);
    in_valid1 = v1; in_valid2 = v2;
    inst_in1 = i1; inst_pc1 = p1;
    inst_in2 = i2; inst_pc2 = p2;
    out_pop = pop; branch_flag = br;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic push2(input int k, input logic [1:0] pop);
    drive(1'b1, 1'b1, inst_of(k), pc_of(k), inst_of(k + 1), pc_of(k + 1), pop, 1'b0);
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("reset_count", inst_count, 64'd0);
    chk("reset_full", instbuf_full, 64'd0);

    // Fill at two per cycle; full at 8; a further push is dropped.
    for (int i = 0; i < 4; i++) begin
      push2(2 * i, 2'd0);
      chk("fill_count", inst_count, 2 * (i + 1));
      chk("fill_full", instbuf_full, (i == 3) ? 64'd1 : 64'd0);
    end
    push2(8, 2'd0);
    chk("drop_count", inst_count, 64'd8);
    chk("drop_head", inst_out1, 64'hA000_0000);

    // Drain to 4, then push 2 / pop 2 keeps 4 and advances the head.
    idle(); out_pop = 2'd2; cycle();
    chk("pop_count6", inst_count, 64'd6);
    cycle();
    chk("pop_count4", inst_count, 64'd4);
    push2(10, 2'd2);
    chk("pp_count", inst_count, 64'd4);
    chk("pp_pc1", pc_out1, 64'h1018);
    chk("pp_pc2", pc_out2, 64'h101C);
    chk("pp_inst1", inst_out1, 64'hA000_0006);

    // Flush held for two cycles while pushing keeps the queue empty.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, inst_of(20), pc_of(20), inst_of(21), pc_of(21), 2'd0, 1'b1);
      cycle();
      chk("hold_flush_count", inst_count, 64'd0);
      chk("hold_flush_v1", out_valid1, 64'd0);
    end

    // Wrap-around: head PC steps by 8 each cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'h5000 + i, 8 * i, 32'h6000 + i, 8 * i + 4, 2'd2, 1'b0);
      cycle();
      chk("wrap_pc1", pc_out1, 8 * i);
    end

    // Build occupancy 6, then flush with a simultaneous push and pop.
    idle();
    for (int j = 0; j < 8 && q_m.size() < 6; j++) push2(100 + 2 * j, 2'd0);
    chk("pre_flush_count", inst_count, 64'd6);
    drive(1'b1, 1'b1, inst_of(120), pc_of(120), inst_of(121), pc_of(121), 2'd1, 1'b1);
    cycle();
    chk("flush_count", inst_count, 64'd0);
    chk("flush_v1", out_valid1, 64'd0);
    chk("flush_full", instbuf_full, 64'd0);
    idle(); cycle();

    // Over-pop is clamped.
    drive(1'b1, 1'b0, inst_of(200), pc_of(200), 32'h0, 32'h0, 2'd0, 1'b0);
    cycle();
    chk("one_count", inst_count, 64'd1);
    chk("one_v2", out_valid2, 64'd0);
    idle(); out_pop = 2'd2; cycle();
    chk("clamp_count", inst_count, 64'd0);
    chk("clamp_v1", out_valid1, 64'd0);

`ifdef INST_QUEUE_BYPASS_EN
    // Bypass: empty queue forwards the input in the same cycle.
    drive(1'b1, 1'b0, 32'h13, 32'h100, 32'h0, 32'h0, 2'd1, 1'b0);
    #1;
    chk("byp_inst1", inst_out1, 64'h13);
    chk("byp_pc1", pc_out1, 64'h100);
    chk("byp_v1", out_valid1, 64'd1);
    cycle();
    chk("byp_count", inst_count, 64'd0);
`endif

    // Reset mid-traffic at occupancy 5.
    idle(); cycle();
    push2(300, 2'd0);
    push2(302, 2'd0);
    drive(1'b1, 1'b0, inst_of(304), pc_of(304), 32'h0, 32'h0, 2'd0, 1'b0);
    cycle();
    chk("pre_rst_count", inst_count, 64'd5);
    idle();
    #2;
    rst = 1'b0;
    q_m.delete();
    #2;
    chk("rst_count", inst_count, 64'd0);
    chk("rst_v1", out_valid1, 64'd0);
    chk("rst_v2", out_valid2, 64'd0);
    chk("rst_full", instbuf_full, 64'd0);
    chk("rst_inst1", inst_out1, 64'd0);
    chk("rst_pc2", pc_out2, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Recovery after reset.
    push2(400, 2'd0);
    chk("post_rst_count", inst_count, 64'd2);
    chk("post_rst_inst1", inst_out1, 64'hA000_0190);
    chk("post_rst_pc2", pc_out2, 64'h1644);
    idle(); cycle();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
